// File: rtl/regbank_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the register-bank
// access sequencer.
package regbank_pkg;

  localparam logic [2:0] OP_READ8   = 3'd0;
  localparam logic [2:0] OP_WRITE8  = 3'd1;
  localparam logic [2:0] OP_READ16  = 3'd2;
  localparam logic [2:0] OP_WRITE16 = 3'd3;
  localparam logic [2:0] OP_INC16   = 3'd4;
  localparam logic [2:0] OP_DEC16   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Word ops address the pair through its even (high-byte) register.
  function automatic logic [2:0] pair_sel(input logic [2:0] r);
    return {r[2:1], 1'b0};
  endfunction

  function automatic logic op_is_16(input logic [2:0] op);
    return (op == OP_READ16) || (op == OP_WRITE16) || (op == OP_INC16) || (op == OP_DEC16);
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_DEC16;
  endfunction

  function automatic logic [15:0] rmw_result(input logic [2:0] op, input logic [15:0] val);
    return (op == OP_INC16) ? (val + 16'd1) : (val - 16'd1);
  endfunction

endpackage

// File: rtl/regbank_rr_arbiter.sv
// Two-way request arbiter with last-grant memory; grants only while enabled
// and out of reset.
module regbank_rr_arbiter #(
  parameter int ARB_MODE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic a_valid,
  input  logic b_valid,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant decision; last_grant_q = 1 means B won the previous acceptance.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (enable && reset) begin
      if (a_valid && b_valid) begin
        if ((ARB_MODE == 1) && (last_grant_q == 1'b0)) begin
          gnt_b = 1'b1;
        end else begin
          gnt_a = 1'b1;
        end
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
    last_grant_d = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_grant_q);
  end

  // Last-grant register; starts as B so the first contest goes to A.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regbank_access_sequencer.sv
// Sequences arbitrated port A/B requests into register-bank strobes, including
// 16-bit read-modify-write, and returns one registered response per request.
module regbank_access_sequencer
  import regbank_pkg::*;
#(
  parameter int ARB_MODE    = 1,
  parameter int BANK_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_op,
  input  logic [2:0]  a_reg,
  input  logic [15:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_op,
  input  logic [2:0]  b_reg,
  input  logic [15:0] b_wdata,
  output logic        rsp_valid,
  output logic        rsp_src,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  rb_reg_num,
  output logic [7:0]  rb_data_in,
  output logic        rb_we,
  output logic [15:0] rb_data_in16,
  output logic        rb_we16,
  input  logic [7:0]  rb_data_out,
  input  logic [15:0] rb_data_out16
);

  localparam logic [1:0] WAIT_LAST = 2'(BANK_RD_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] wdata_q, wdata_d;
  logic        src_q, src_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_src_q, rsp_src_d, rsp_err_q, rsp_err_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;
  logic [2:0]  rb_reg_num_q, rb_reg_num_d;
  logic        rb_we_q, rb_we_d, rb_we16_q, rb_we16_d;
  logic [7:0]  rb_data_in_q, rb_data_in_d;
  logic [15:0] rb_data_in16_q, rb_data_in16_d;

  logic        gnt_a_s, gnt_b_s;
  logic [2:0]  sel_op_s, sel_reg_s;
  logic [15:0] sel_wdata_s;

  regbank_rr_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_q == ST_IDLE),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .gnt_a   (gnt_a_s),
    .gnt_b   (gnt_b_s)
  );

  assign a_ready     = gnt_a_s;
  assign b_ready     = gnt_b_s;
  assign sel_op_s    = gnt_b_s ? b_op : a_op;
  assign sel_reg_s   = gnt_b_s ? b_reg : a_reg;
  assign sel_wdata_s = gnt_b_s ? b_wdata : a_wdata;

  // Next-state and next-output logic; strobes and response fields default low.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wdata_d        = wdata_q;
    src_d          = src_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    rsp_valid_d    = 1'b0;
    rsp_src_d      = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_data_d     = 16'h0000;
    rb_reg_num_d   = 3'd0;
    rb_we_d        = 1'b0;
    rb_we16_d      = 1'b0;
    rb_data_in_d   = 8'h00;
    rb_data_in16_d = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (gnt_a_s || gnt_b_s) begin
          op_d    = sel_op_s;
          wdata_d = sel_wdata_s;
          src_d   = gnt_b_s;
          if (!op_legal(sel_op_s)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_src_d   = gnt_b_s;
            rsp_err_d   = 1'b1;
          end else begin
            state_d        = ST_ISSUE;
            rb_reg_num_d   = op_is_16(sel_op_s) ? pair_sel(sel_reg_s) : sel_reg_s;
            rb_we_d        = (sel_op_s == OP_WRITE8);
            rb_data_in_d   = (sel_op_s == OP_WRITE8) ? sel_wdata_s[7:0] : 8'h00;
            rb_we16_d      = (sel_op_s == OP_WRITE16);
            rb_data_in16_d = (sel_op_s == OP_WRITE16) ? sel_wdata_s : 16'h0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if ((op_q == OP_WRITE8) || (op_q == OP_WRITE16)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_src_d   = src_q;
          rsp_data_d  = (op_q == OP_WRITE8) ? {8'h00, wdata_q[7:0]} : wdata_q;
        end else begin
          state_d      = ST_WAIT;
          cnt_d        = WAIT_LAST;
          rb_reg_num_d = rb_reg_num_q;
        end
      end
      ST_WAIT: begin
        rb_reg_num_d = rb_reg_num_q;
        if (cnt_q == 2'd0) begin
          case (op_q)
            OP_READ8: begin
              state_d      = ST_RESP;
              rb_reg_num_d = 3'd0;
              rsp_valid_d  = 1'b1;
              rsp_src_d    = src_q;
              rsp_data_d   = {8'h00, rb_data_out};
            end
            OP_READ16: begin
              state_d      = ST_RESP;
              rb_reg_num_d = 3'd0;
              rsp_valid_d  = 1'b1;
              rsp_src_d    = src_q;
              rsp_data_d   = rb_data_out16;
            end
            default: begin
              // INC16/DEC16: write back the updated word to the same pair.
              state_d        = ST_WB;
              rb_we16_d      = 1'b1;
              rb_data_in16_d = rmw_result(op_q, rb_data_out16);
              data_d         = rmw_result(op_q, rb_data_out16);
            end
          endcase
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_WB: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_src_d   = src_q;
        rsp_data_d  = data_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, context and registered outputs; reset abandons any in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      op_q           <= 3'd0;
      wdata_q        <= 16'h0000;
      src_q          <= 1'b0;
      cnt_q          <= 2'd0;
      data_q         <= 16'h0000;
      rsp_valid_q    <= 1'b0;
      rsp_src_q      <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= 16'h0000;
      busy_q         <= 1'b0;
      rb_reg_num_q   <= 3'd0;
      rb_we_q        <= 1'b0;
      rb_we16_q      <= 1'b0;
      rb_data_in_q   <= 8'h00;
      rb_data_in16_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      wdata_q        <= wdata_d;
      src_q          <= src_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_src_q      <= rsp_src_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
      busy_q         <= busy_d;
      rb_reg_num_q   <= rb_reg_num_d;
      rb_we_q        <= rb_we_d;
      rb_we16_q      <= rb_we16_d;
      rb_data_in_q   <= rb_data_in_d;
      rb_data_in16_q <= rb_data_in16_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_src      = rsp_src_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = busy_q;
  assign rb_reg_num   = rb_reg_num_q;
  assign rb_we        = rb_we_q;
  assign rb_we16      = rb_we16_q;
  assign rb_data_in   = rb_data_in_q;
  assign rb_data_in16 = rb_data_in16_q;

endmodule

// File: tb/tb_regbank_access_sequencer.sv
// Scoreboard bench: two sequencers (RR/latency 1 and fixed-priority/latency 2)
// each driving a behavioural register bank.
module tb_regbank_access_sequencer;
  import regbank_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       a_valid, a_ready, b_valid, b_ready;
  logic [1:0][2:0]  a_op, a_reg, b_op, b_reg;
  logic [1:0][15:0] a_wdata, b_wdata;
  logic [1:0]       rsp_valid, rsp_src, rsp_err, busy, rb_we, rb_we16;
  logic [1:0][15:0] rsp_data, rb_data_in16, rb_data_out16;
  logic [1:0][2:0]  rb_reg_num;
  logic [1:0][7:0]  rb_data_in, rb_data_out;

  typedef struct {
    logic        src;
    logic [15:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int compared = 0;
  int errs = 0;
  int cyc = 0;
  int we16_cnt[2];
  int strobe_cnt[2];
  logic [2:0] last_reg16[2];

  logic [7:0] bank [2][8];
  logic [1:0][23:0] s1, s2;

  regbank_access_sequencer #(.ARB_MODE(1), .BANK_RD_LAT(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_op(a_op[0]), .a_reg(a_reg[0]), .a_wdata(a_wdata[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_op(b_op[0]), .b_reg(b_reg[0]), .b_wdata(b_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_src(rsp_src[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]), .rb_reg_num(rb_reg_num[0]), .rb_data_in(rb_data_in[0]), .rb_we(rb_we[0]),
    .rb_data_in16(rb_data_in16[0]), .rb_we16(rb_we16[0]),
    .rb_data_out(rb_data_out[0]), .rb_data_out16(rb_data_out16[0])
  );

  regbank_access_sequencer #(.ARB_MODE(0), .BANK_RD_LAT(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_op(a_op[1]), .a_reg(a_reg[1]), .a_wdata(a_wdata[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_op(b_op[1]), .b_reg(b_reg[1]), .b_wdata(b_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_src(rsp_src[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]), .rb_reg_num(rb_reg_num[1]), .rb_data_in(rb_data_in[1]), .rb_we(rb_we[1]),
    .rb_data_in16(rb_data_in16[1]), .rb_we16(rb_we16[1]),
    .rb_data_out(rb_data_out[1]), .rb_data_out16(rb_data_out16[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank: writes on strobes, reads through a 1- or 2-stage pipe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rb_we[i]) bank[i][rb_reg_num[i]] <= rb_data_in[i];
      if (rb_we16[i]) begin
        bank[i][{rb_reg_num[i][2:1], 1'b0}] <= rb_data_in16[i][15:8];
        bank[i][{rb_reg_num[i][2:1], 1'b1}] <= rb_data_in16[i][7:0];
      end
      s1[i] <= {bank[i][rb_reg_num[i]], bank[i][{rb_reg_num[i][2:1], 1'b0}],
                bank[i][{rb_reg_num[i][2:1], 1'b1}]};
      s2[i] <= s1[i];
    end
  end

  assign rb_data_out[0]   = s1[0][23:16];
  assign rb_data_out16[0] = s1[0][15:0];
  assign rb_data_out[1]   = s2[1][23:16];
  assign rb_data_out16[1] = s2[1][15:0];

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s (inst %0d): got 0x%0h, required 0x%0h", name, inst, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int lat_of(input int i, input logic [2:0] op);
    int rl = (i == 0) ? 1 : 2;
    case (op)
      OP_WRITE8, OP_WRITE16: return 2;
      OP_READ8, OP_READ16:   return 2 + rl;
      OP_INC16, OP_DEC16:    return 3 + rl;
      default:               return 1;
    endcase
  endfunction

  function automatic logic rdy(input int i, input bit port);
    return port ? b_ready[i] : a_ready[i];
  endfunction

  task automatic mon(input int i);
    exp_t e;
    logic bad;
    bad = (a_ready[i] & b_ready[i]) | ((a_ready[i] | b_ready[i]) & (rsp_valid[i] | busy[i])) |
          (rb_we[i] & rb_we16[i]) | (!rb_we[i] && rb_data_in[i] != 8'h00) |
          (!rb_we16[i] && rb_data_in16[i] != 16'h0000);
    chk("invariants", i, bad, 0);
    if (rb_we[i] | rb_we16[i]) strobe_cnt[i]++;
    if (rb_we16[i]) begin
      we16_cnt[i]++;
      last_reg16[i] = rb_reg_num[i];
    end
    if (rsp_valid[i]) begin
      if (qsize(i) == 0) begin
        compared++;
        errs++;
        $display("FAIL unexpected_rsp (inst %0d): got rsp_valid=1 data 0x%0h, required no response", i, rsp_data[i]);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk("rsp_src", i, rsp_src[i], e.src);
        chk("rsp_data", i, rsp_data[i], e.data);
        chk("rsp_err", i, rsp_err[i], e.err);
        chk("latency", i, cyc - e.acc + 1, e.lat);
      end
    end
  endtask

  task automatic drive(input int i, input bit port, input bit v, input logic [2:0] op,
                       input logic [2:0] rg, input logic [15:0] wd);
    if (!port) begin
      a_valid[i] = v; a_op[i] = op; a_reg[i] = rg; a_wdata[i] = wd;
    end else begin
      b_valid[i] = v; b_op[i] = op; b_reg[i] = rg; b_wdata[i] = wd;
    end
  endtask

  task automatic wait_idle(input int i);
    int guard = 0;
    while (qsize(i) != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (qsize(i) != 0) begin
      compared++;
      errs++;
      $display("FAIL rsp_timeout (inst %0d): got %0d pending, required 0", i, qsize(i));
      if (i == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic issue(input int i, input bit port, input logic [2:0] op, input logic [2:0] rg,
                       input logic [15:0] wd, input logic [15:0] exp_d, input bit exp_e,
                       input bit push_exp, input bit wait_done);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    drive(i, port, 1'b1, op, rg, wd);
    #1;
    while (!rdy(i, port) && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!rdy(i, port)) begin
      compared++;
      errs++;
      $display("FAIL accept_timeout (inst %0d): got ready=0, required ready=1", i);
      drive(i, port, 1'b0, op, rg, wd);
      return;
    end
    if (push_exp) begin
      e.src = port; e.data = exp_d; e.err = exp_e; e.lat = lat_of(i, op); e.acc = cyc + 1;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    drive(i, port, 1'b0, op, rg, wd);
    if (wait_done) wait_idle(i);
  endtask

  // Both ports request WRITE8 continuously; bit n of exp_seq is the n-th grantee (1 = B).
  task automatic contend(input int i, input logic [3:0] exp_seq);
    int n = 0;
    int guard = 0;
    exp_t e;
    logic got;
    @(negedge clk);
    drive(i, 1'b0, 1'b1, OP_WRITE8, 3'd4, 16'h0011);
    drive(i, 1'b1, 1'b1, OP_WRITE8, 3'd1, 16'h0022);
    while (n < 4 && guard < 200) begin
      #1;
      if (a_ready[i] | b_ready[i]) begin
        got = b_ready[i];
        chk("grant_order", i, got, exp_seq[n]);
        e.src = got; e.data = got ? 16'h0022 : 16'h0011; e.err = 1'b0; e.lat = 2; e.acc = cyc + 1;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        n++;
      end
      @(negedge clk);
      guard++;
    end
    chk("grant_count", i, n, 4);
    drive(i, 1'b0, 1'b0, OP_WRITE8, 3'd4, 16'h0011);
    drive(i, 1'b1, 1'b0, OP_WRITE8, 3'd1, 16'h0022);
    wait_idle(i);
  endtask

  initial begin
    int snap;
    int guard;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000);
      drive(i, 1'b1, 1'b0, 3'd0, 3'd0, 16'h0000);
      we16_cnt[i] = 0;
      strobe_cnt[i] = 0;
      last_reg16[i] = 3'd0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) mon(i);
      end
    join_none

    #2 reset = 1'b0;
    a_valid[0] = 1'b1;
    b_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_rsp_valid", i, rsp_valid[i], 0);
      chk("rst_ready", i, {a_ready[i], b_ready[i]}, 0);
      chk("rst_strobes", i, {rb_we[i], rb_we16[i], rb_reg_num[i]}, 0);
    end
    a_valid[0] = 1'b0;
    b_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    contend(0, 4'b1010);
    contend(1, 4'b0000);

    issue(0, 1'b0, OP_WRITE8, 3'd5, 16'h77A5, 16'h00A5, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, OP_READ8,  3'd5, 16'h0000, 16'h00A5, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b1, OP_WRITE16, 3'd3, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    chk("we16_pair_sel", 0, last_reg16[0], 3'd2);
    issue(0, 1'b1, OP_READ16, 3'd2, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, OP_WRITE16, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    snap = we16_cnt[0];
    issue(0, 1'b0, OP_INC16, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("inc_we16_once", 0, we16_cnt[0] - snap, 1);
    issue(0, 1'b0, OP_READ16, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, OP_WRITE16, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    snap = we16_cnt[0];
    issue(0, 1'b1, OP_DEC16, 3'd7, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk("dec_we16_once", 0, we16_cnt[0] - snap, 1);
    issue(0, 1'b1, OP_READ8, 3'd7, 16'h0000, 16'h00FF, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, OP_READ8, 3'd6, 16'h0000, 16'h00FF, 1'b0, 1'b1, 1'b1);
    snap = strobe_cnt[0];
    issue(0, 1'b0, 3'd7, 3'd2, 16'hDEAD, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(0, 1'b1, 3'd6, 3'd4, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b1);
    chk("illegal_no_strobe", 0, strobe_cnt[0] - snap, 0);

    issue(0, 1'b0, OP_WRITE16, 3'd2, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, OP_INC16, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!rb_we16[0] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("wb_reached", 0, rb_we16[0], 1);
    reset = 1'b0;
    #1;
    chk("rst_we16_drop", 0, {rb_we16[0], rb_data_in16[0]}, 0);
    chk("rst_busy_mid", 0, busy[0], 0);
    chk("rst_no_rsp", 0, rsp_valid[0], 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(0, 1'b0, OP_READ16, 3'd3, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1);

    issue(1, 1'b0, OP_WRITE8, 3'd5, 16'h00A5, 16'h00A5, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b0, OP_READ8,  3'd5, 16'h0000, 16'h00A5, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b0, OP_WRITE16, 3'd4, 16'h00FF, 16'h00FF, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b1, OP_INC16, 3'd5, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b0, OP_READ16, 3'd4, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b1, OP_WRITE16, 3'd3, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b1, OP_READ16, 3'd2, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b0, 3'd7, 3'd0, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end

endmodule

// File: doc/regbank_access_sequencer.md
Name: regbank_access_sequencer

Overview:
- Sequences all accesses to the CPU register bank: 8 x 8-bit registers, with pairs 0/1, 2/3, 4/5 and 6/7 also accessible as 16-bit words, even register in the high byte.
- Arbitrates between two requesters: port A (instruction core) and port B (debug/DMA).
- Converts each accepted request into correctly timed bank strobes, including 16-bit INC/DEC read-modify-write.
- Returns one response pulse per accepted request.

Parameters:
- ARB_MODE, 1: arbitration policy. 1 = round-robin when both ports request; 0 = fixed priority to A.
- BANK_RD_LAT, 1: cycles from a stable rb_reg_num to valid rb_data_out/rb_data_out16. Legal values are 1 and 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 asserts).
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_op  in  3  op code: 0 READ8, 1 WRITE8, 2 READ16, 3 WRITE16, 4 INC16, 5 DEC16, 6-7 illegal.
- a_reg  in  3  register number; bit 0 is ignored for 16-bit ops.
- a_wdata  in  16  write data; WRITE8 uses [7:0].
- b_valid, b_ready, b_op, b_reg, b_wdata  as port A, for port B.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_src  out  1  requester the response belongs to: 0 = A, 1 = B.
- rsp_data  out  16  result value.
- rsp_err  out  1  set on the response to an illegal op.
- busy  out  1  high whenever the state is not IDLE.
- rb_reg_num  out  3  bank register select.
- rb_data_in  out  8  bank 8-bit write data.
- rb_we  out  1  bank 8-bit write enable.
- rb_data_in16  out  16  bank 16-bit write data.
- rb_we16  out  1  bank 16-bit write enable.
- rb_data_out  in  8  bank 8-bit read data.
- rb_data_out16  in  16  bank 16-bit read data.

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=B. All outputs 0, including a_ready, b_ready, rsp_*, busy, rb_*. The bank strobes drop immediately; an in-flight op is abandoned with no response.
- Handshake:
  - a_ready/b_ready are combinational and can only be high in IDLE. At most one is high per cycle.
  - A request is accepted on the edge where valid&ready. op/reg/wdata are latched then.
  - Requesters hold valid and payload stable until accepted. valid may drop without acceptance.
- Arbitration in IDLE:
  - One port valid: grant it.
  - Both valid, ARB_MODE=1: grant the port not equal to last_grant. The first contest after reset grants A.
  - Both valid, ARB_MODE=0: grant A.
  - last_grant updates on each acceptance.
- States: IDLE, ISSUE, WAIT, WB, RESP.
  - IDLE -> ISSUE on acceptance; IDLE -> RESP directly for illegal ops.
  - ISSUE (1 cycle):
    - Drive rb_reg_num: reg for 8-bit ops; {reg[2:1],1'b0} for 16-bit ops.
    - WRITE8: rb_we=1, rb_data_in=wdata[7:0].
    - WRITE16: rb_we16=1, rb_data_in16=wdata.
    - Writes go ISSUE -> RESP. Reads and INC/DEC go ISSUE -> WAIT.
  - WAIT:
    - Counter holds rb_reg_num for BANK_RD_LAT cycles, then captures rb_data_out (8-bit) or rb_data_out16.
    - READ -> RESP; INC/DEC -> WB.
  - WB (1 cycle): rb_we16=1, rb_data_in16 = captured+1 (INC16) or captured-1 (DEC16), modulo 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF). WB -> RESP.
  - RESP (1 cycle): rsp_valid=1 and rsp_src=granted port, then -> IDLE. rsp_data per op:
    - READ8: {8'h00, byte}.
    - READ16: the captured word.
    - WRITE8: {8'h00, wdata[7:0]}.
    - WRITE16: wdata.
    - INC/DEC: the new value.
    - Illegal: 0 with rsp_err=1, and no bank strobe.
- Strobes: rb_we and rb_we16 are never high together, and never high outside ISSUE/WB. rb_data_in* is 0 when its strobe is low.
- Latency, acceptance edge to rsp_valid cycle: write 2 cycles; read 2+BANK_RD_LAT; INC/DEC 3+BANK_RD_LAT; illegal 1.
- Throughput: a new request can be accepted only in the cycle after RESP; rsp_valid and ready are never both high.

Decomposition:
- Shared package regbank_pkg holds:
  - op code localparams: OP_READ8 .. OP_DEC16;
  - state encodings;
  - the pair-select helper (clear bit 0).
- One sub-module, regbank_rr_arbiter: 2-way grant plus last_grant register, with ARB_MODE passed through.
- FSM, latency counter and datapath muxes stay in the top module.

Test Plan:
- Reset mid-op: assert reset=0 during WB of an INC16 on pair 2 preloaded 0x1234 -> rb_we16 drops at once, no rsp_valid, pair stays 0x1234, busy=0.
- A WRITE8 reg5 0xA5, then A READ8 reg5 -> write response rsp_data=0x00A5 two cycles after acceptance; read returns 0x00A5 after 2+BANK_RD_LAT cycles. Repeat with BANK_RD_LAT=2.
- B WRITE16 reg3 (pair 2) 0xBEEF -> bank sees rb_reg_num=2 and rb_we16=1; then READ16 reg2 -> 0xBEEF, rsp_src=1.
- INC16 pair 0 at 0xFFFF -> rsp_data=0x0000; DEC16 pair 6 at 0x0000 -> 0xFFFF, rb_we16 pulses exactly once each.
- A and B both valid continuously, ARB_MODE=1 -> grants alternate A,B,A,B; ARB_MODE=0 -> A always, B is never ready.
- A op=7 -> rsp_valid one cycle after acceptance, rsp_err=1, rsp_data=0, no rb_we or rb_we16 observed.
